// File: rtl/awgn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// awgn_pkg: shared constants and helpers for the multi-channel AWGN source
// Rev 1.0
// ----------------------------------------------------------------------------
package awgn_pkg;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int CLT_OFFSET = 510;
  localparam int CAL_GAIN   = 111;
  localparam int CAL_SHIFT  = 7;
  localparam int Z_W        = 10;

  // Galois form: shift right, fold the taps back in when a one drops out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] r, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/lfsr_clt_normal.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_clt_normal: one LFSR plus the 4-byte CLT sum and unit-variance scaling
// Rev 1.0
// ----------------------------------------------------------------------------
module lfsr_clt_normal
  import awgn_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0005
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  en,
  output logic signed [Z_W-1:0] z
);
  // An all-zero state would lock the LFSR forever.
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0]        lfsr;
  logic [31:0]        lfsr_nxt;
  logic [9:0]         byte_sum;
  logic signed [10:0] u;

  assign lfsr_nxt = lfsr_step(lfsr);
  assign byte_sum = 10'(lfsr_nxt[7:0]) + 10'(lfsr_nxt[15:8])
                  + 10'(lfsr_nxt[23:16]) + 10'(lfsr_nxt[31:24]);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_NZ;
      u    <= '0;
      z    <= '0;
    end else if (adv) begin
      if (en) begin
        lfsr <= lfsr_nxt;
        u    <= $signed({1'b0, byte_sum}) - 11'(CLT_OFFSET);
      end
      z <= Z_W'((19'(u) * 19'(CAL_GAIN)) >>> CAL_SHIFT);
    end
  end
endmodule
`default_nettype wire

// File: rtl/awgn_multi_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// awgn_multi_gen: N-channel Gaussian noise, runtime mean/std, saturated output
// Rev 1.0
// ----------------------------------------------------------------------------
module awgn_multi_gen
  import awgn_pkg::*;
#(
  parameter int          N_CH        = 2,
  parameter int          W           = 16,
  parameter int          STD_FRAC    = 8,
  parameter logic [31:0] SEED        = 32'h0000_0005,
  parameter logic [31:0] SEED_STRIDE = 32'h9E37_79B9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [W-1:0]      mean_i,
  input  logic [15:0]       std_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [N_CH*W-1:0] noise_o,
  output logic [N_CH-1:0]   sat_o
);
  localparam int PW = Z_W + 17;
  localparam int RW = ((W > PW - STD_FRAC) ? W : (PW - STD_FRAC)) + 1;

  logic v1;
  logic v2;
  logic v3;
  logic adv;

  // The whole pipeline freezes while a finished sample waits downstream.
  assign adv         = !v3 || out_ready_i;
  assign out_valid_o = v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= en_i;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    localparam logic [31:0] CH_SEED = 32'(SEED + 32'(ch) * SEED_STRIDE);

    logic signed [Z_W-1:0] z;
    logic signed [RW-1:0]  r;
    logic [W-1:0]          noise_q;
    logic                  sat_q;

    lfsr_clt_normal #(.SEED(CH_SEED)) u_gen (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .en  (en_i),
      .z   (z)
    );

    assign r = RW'((PW'(z) * $signed({{(PW-16){1'b0}}, std_i})) >>> STD_FRAC)
             + RW'($signed(mean_i));

    always_ff @(posedge clk) begin
      if (rst) begin
        noise_q <= '0;
        sat_q   <= 1'b0;
      end else if (adv) begin
        noise_q <= W'(saturate(32'(r), W));
        sat_q   <= (saturate(32'(r), W) != 32'(r));
      end
    end

    assign noise_o[ch*W +: W] = noise_q;
    assign sat_o[ch]          = sat_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_awgn_multi_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_awgn_multi_gen: reference-model checks of the AWGN source stream
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_awgn_multi_gen;
  localparam int          N_CH   = 2;
  localparam int          W      = 16;
  localparam logic [31:0] SEED   = 32'h0000_0005;
  localparam logic [31:0] STRIDE = 32'h9E37_79B9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en_i = 1'b0;
  logic [W-1:0]      mean_i = '0;
  logic [15:0]       std_i = '0;
  logic              out_ready_i = 1'b0;
  logic              out_valid_o;
  logic [N_CH*W-1:0] noise_o;
  logic [N_CH-1:0]   sat_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  awgn_multi_gen #(
    .N_CH(N_CH), .W(W), .STD_FRAC(8), .SEED(SEED), .SEED_STRIDE(STRIDE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .mean_i      (mean_i),
    .std_i       (std_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .noise_o     (noise_o),
    .sat_o       (sat_o)
  );

  // ---------------- reference model (integer arithmetic) ----------------
  logic [31:0] m_lfsr [N_CH];
  int  cfg_mean = 0;
  int  cfg_std  = 0;
  int  n_acc = 0;
  int  n_since_rst = 0;
  bit  pin_on = 1'b0;
  bit  stats_on = 1'b0;
  real s_x [N_CH];
  real s_xx [N_CH];
  real s_xy = 0.0;
  int  n_stat = 0;
  int  sat_hi = 0;
  int  sat_lo = 0;

  function automatic logic [31:0] seed_of(input int ch);
    logic [31:0] s;
    s = SEED + 32'(ch) * STRIDE;
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int zval(input logic [31:0] s);
    int sum;
    sum = int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]);
    return fdiv((sum - 510) * 111, 128);
  endfunction

  function automatic int expect_val(input int z, input int sd, input int mn, output bit sat);
    int r;
    r = fdiv(z * sd, 256) + mn;
    sat = 1'b1;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    sat = 1'b0;
    return r;
  endfunction

  task automatic chk(input int act, input int exp, input string name);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int          got [N_CH];
    int          e;
    bit          esat;
    logic [31:0] nxt;
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) m_lfsr[ch] = seed_of(ch);
      n_since_rst = 0;
    end else if (out_valid_o) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        nxt = lstep(m_lfsr[ch]);
        e = expect_val(zval(nxt), cfg_std, cfg_mean, esat);
        got[ch] = int'($signed(noise_o[ch*W +: W]));
        checks++;
        if (got[ch] != e || sat_o[ch] != esat) begin
          errors++;
          $display("FAIL stream ch%0d idx %0d: got %0d sat %0b, expected %0d sat %0b",
                   ch, n_since_rst, got[ch], sat_o[ch], e, esat);
        end
        if (sat_o[ch] && got[ch] == 32767) sat_hi++;
        if (sat_o[ch] && got[ch] == -32768) sat_lo++;
      end
      if (out_ready_i) begin
        if (pin_on && n_since_rst == 0) begin
          chk(got[0], -303, "pin ch0 sample0");
          chk(got[1], 6, "pin ch1 sample0");
        end
        if (pin_on && n_since_rst == 1) chk(got[0], -232, "pin ch0 sample1");
        if (stats_on) begin
          for (int ch = 0; ch < N_CH; ch++) begin
            s_x[ch]  += real'(got[ch]);
            s_xx[ch] += real'(got[ch]) * real'(got[ch]);
          end
          s_xy += real'(got[0]) * real'(got[1]);
          n_stat++;
        end
        for (int ch = 0; ch < N_CH; ch++) m_lfsr[ch] = lstep(m_lfsr[ch]);
        n_acc++;
        n_since_rst++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_samples(input int n);
    int target;
    int cyc;
    target = n_acc + n;
    cyc = 0;
    while (n_acc < target && cyc < 4 * n + 20) begin
      tick();
      cyc++;
    end
    chk(int'(n_acc >= target), 1, "sample budget");
  endtask

  task automatic drain();
    en_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) tick();
  endtask

  task automatic set_cfg(input int mn, input int sd);
    cfg_mean = mn;
    cfg_std  = sd;
    mean_i   = W'(mn);
    std_i    = 16'(sd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH*W-1:0] held;
    real m, sd, sd1, corr;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk(int'(out_valid_o), 0, "reset out_valid");
    chk(int'(noise_o), 0, "reset noise");
    chk(int'(sat_o), 0, "reset sat");

    // Constant output and 3-cycle latency
    tick();
    set_cfg(100, 0);
    rst = 1'b0;
    en_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(int'(out_valid_o), (i == 3) ? 1 : 0, "latency valid");
    end
    run_samples(20);
    drain();

    // Golden sequence from seeds
    rst = 1'b1;
    out_ready_i = 1'b0;
    tick();
    tick();
    set_cfg(0, 256);
    pin_on = 1'b1;
    rst = 1'b0;
    en_i = 1'b1;
    out_ready_i = 1'b1;
    run_samples(64);

    // Backpressure: outputs frozen for 5 stalled cycles
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) held = noise_o;
      else chk(int'(noise_o == held && out_valid_o), 1, "stall hold");
    end
    tick();
    out_ready_i = 1'b1;
    run_samples(20);

    // Bubbles mixed with intermittent ready
    for (int i = 0; i < 24; i++) begin
      en_i = (i % 3) != 0;
      out_ready_i = (i % 4) != 1;
      tick();
    end
    en_i = 1'b1;
    out_ready_i = 1'b1;
    run_samples(10);

    // Reset mid-stream
    rst = 1'b1;
    out_ready_i = 1'b0;
    tick();
    rst = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk(int'(out_valid_o), 0, "valid after mid reset");
    tick();
    run_samples(20);

    // Statistics
    s_xy = 0.0;
    for (int ch = 0; ch < N_CH; ch++) begin
      s_x[ch] = 0.0;
      s_xx[ch] = 0.0;
    end
    n_stat = 0;
    stats_on = 1'b1;
    run_samples(65536);
    stats_on = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m  = s_x[ch] / n_stat;
      sd = $sqrt(s_xx[ch] / n_stat - m * m);
      checks++;
      if (m > 4.0 || m < -4.0 || sd > 132.0 || sd < 124.0) begin
        errors++;
        $display("FAIL stats ch%0d: mean %f std %f, expected |mean|<=4 std 128+-4", ch, m, sd);
      end
    end
    m   = s_x[0] / n_stat;
    sd  = $sqrt(s_xx[0] / n_stat - m * m);
    sd1 = $sqrt(s_xx[1] / n_stat - (s_x[1] / n_stat) * (s_x[1] / n_stat));
    corr = (s_xy / n_stat - m * (s_x[1] / n_stat)) / (sd * sd1);
    checks++;
    if (corr > 0.02 || corr < -0.02) begin
      errors++;
      $display("FAIL correlation: got %f, expected |corr| < 0.02", corr);
    end
    pin_on = 1'b0;
    drain();

    // Saturation, positive then negative
    set_cfg(32700, 16'h0400);
    en_i = 1'b1;
    run_samples(64);
    drain();
    chk(int'(sat_hi > 0), 1, "saturation high seen");
    set_cfg(-32700, 16'h0400);
    en_i = 1'b1;
    run_samples(64);
    drain();
    chk(int'(sat_lo > 0), 1, "saturation low seen");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/awgn_multi_gen.md
Name: awgn_multi_gen

Overview:
- Parametrised multi-channel additive-white-Gaussian-noise source for the channel-simulation path. Successor to the single-channel fixed mean/std noise generator.
- Each channel runs its own 32-bit Galois LFSR. A 4-term central-limit sum of the LFSR bytes, calibrated to unit variance, forms the Gaussian approximation.
- Mean and std are set at runtime. The output is saturated and delivered through a valid/ready handshake with full-pipeline stall.

Parameters:
- N_CH, 2, number of independent noise channels (1..16).
- W, 16, output sample width, signed, 2^7 quantisation (128 LSB = 1.0).
- STD_FRAC, 8, fractional bits of std_i (unsigned Q(16-STD_FRAC).STD_FRAC).
- SEED, 32'h0000_0005, LFSR seed of channel 0.
- SEED_STRIDE, 32'h9E37_79B9, seed increment per channel: seed_ch = SEED + ch*SEED_STRIDE mod 2^32.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  request a new sample set on every advancing cycle.
- mean_i  in  W  signed mean, shared by all channels.
- std_i  in  16  unsigned std scale, shared by all channels.
- out_ready_i  in  1  downstream ready.
- out_valid_o  out  1  noise_o/sat_o hold a valid sample set.
- noise_o  out  N_CH*W  packed signed samples; channel ch occupies bits [ch*W +: W].
- sat_o  out  N_CH  per-channel saturation flag, aligned with noise_o.

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset:
  - out_valid_o=0, noise_o=0, sat_o=0.
  - All pipeline valid bits cleared.
  - Each LFSR loaded with seed_ch; a seed_ch of 0 is replaced by 32'h1.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1 (taps mask 32'h8020_0003). Shifts one step per advance.
- Advance: adv = !v3 | out_ready_i. When adv=0, every pipeline register and every LFSR holds.
- Pipeline (latency 3 advancing cycles from en_i to out_valid_o). When adv=1, the valid bits move v1<=en_i, v2<=v1, v3<=v2, and each stage loads as follows:
  - Stage 1, on adv&en_i:
    - Step the LFSR.
    - s = sum of the four bytes of the new LFSR state (0..1020, 10 bits).
    - u = s - 510, signed 11 bits.
  - Stage 2: z = (u*111) >>> 7, arithmetic shift. z is signed 10 bits, range -443..442, std ≈128 LSB.
  - Stage 3:
    - p = (z*std_i) >>> STD_FRAC, signed.
    - r = p + mean_i, computed in max(W, 27-STD_FRAC)+1 bits.
    - Clamp r to [-2^(W-1), 2^(W-1)-1] into noise_o. sat_o[ch]=1 iff clamped.
    - mean_i and std_i are sampled at this stage load, not at en_i.
- out_valid_o = v3. A transfer occurs when out_valid_o & out_ready_i.
- Backpressure: while out_valid_o=1 and out_ready_i=0, outputs hold stable and no LFSR advances. The emitted sequence is therefore independent of stall pattern.
- en_i=0 inserts bubbles. LFSRs do not step on bubble cycles.
- Config changes mid-stream affect only samples whose stage 3 loads after the change.
- Reset mid-operation: in-flight samples are discarded and the sequence restarts from the seeds on the next cycle.

Decomposition:
- Shared package awgn_pkg: LFSR taps mask, CLT offset 510, calibration constant 111 and its shift 7, and the W-bit saturate helper function.
- Sub-module lfsr_clt_normal: one LFSR plus stages 1–2, with its seed as a parameter. Instantiated N_CH times in a generate loop. Stage 3, the handshake and the valid bits live in the top module.

Test Plan:
- Constant output: N_CH=2; rst 2 cycles, then en_i=1, out_ready_i=1, std_i=0, mean_i=100 → out_valid_o rises on the 3rd cycle after en_i. Both channels read 100 and sat_o=0 every cycle.
- Golden sequence: std_i=16'h0100, mean_i=0 → first 64 samples per channel bit-exact against the bench C model seeded with SEED and SEED+SEED_STRIDE.
- Backpressure: from steady state, hold out_ready_i=0 for 5 cycles → noise_o stable during the stall. The subsequent accepted stream equals the no-stall golden stream with no sample lost or duplicated.
- Saturation: mean_i=32700, std_i=16'h0400 → any sample exceeding 32767 reads 32767 with sat_o[ch]=1. Mirror with mean_i=-32700 → floor of -32768.
- Statistics: std_i=16'h0100, mean_i=0, 65536 samples → per-channel mean within ±4 and std in 128±4. Inter-channel |correlation| < 0.02.
- Reset mid-stream: assert rst for 1 cycle after 10 samples → out_valid_o=0 next cycle. The stream then repeats the golden sequence from sample 0.
